// File: rtl/hazard_ctrl_if.sv
// Operand-hazard / MDU-interlock signal bundle shared between the ID stage and hazard_ctrl.
// master = pipeline side driving hazard sources, slave = the controller producing selects and stalls.
interface hazard_ctrl_if #(
  parameter int NSRC = 2,
  parameter int NSTG = 2
);
  localparam int FS_W = $clog2(NSTG + 1);

  logic                   id_valid;
  logic [NSRC*5-1:0]      id_src_reg;
  logic [NSRC-1:0]        id_src_use;
  logic                   id_md_start;
  logic                   id_md_div;
  logic                   id_hilo_use;
  logic [NSTG-1:0]        stg_wen;
  logic [NSTG*5-1:0]      stg_reg;
  logic [NSTG-1:0]        stg_is_load;
  logic                   flush;

  logic [NSRC*FS_W-1:0]   fwd_sel;
  logic                   stall_id;
  logic                   md_busy;
  logic                   md_done;
  logic [31:0]            stall_cnt;

  modport master (
    output id_valid, id_src_reg, id_src_use, id_md_start, id_md_div, id_hilo_use,
    output stg_wen, stg_reg, stg_is_load, flush,
    input  fwd_sel, stall_id, md_busy, md_done, stall_cnt
  );

  modport slave (
    input  id_valid, id_src_reg, id_src_use, id_md_start, id_md_div, id_hilo_use,
    input  stg_wen, stg_reg, stg_is_load, flush,
    output fwd_sel, stall_id, md_busy, md_done, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Forwarding select, load-use stall and MULT/DIV busy interlock for the ID stage.
// Optional feature macro: HAZ_MDU_INTERLOCK_EN builds the MDU busy FSM and its interlock.
module hazard_ctrl #(
  parameter int NSRC    = 2,
  parameter int NSTG    = 2,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 32
) (
  input logic         clk,
  input logic         resetn,
  hazard_ctrl_if.slave hz
);
  localparam int FS_W = $clog2(NSTG + 1);

  logic [NSRC*FS_W-1:0] fwdSel;
  logic                 loadUse;
  logic                 mduHaz;
  logic                 stallId;
  logic                 mdBusy;
  logic                 mdDone;
  logic [31:0]          stallCnt_q;
  logic [31:0]          stallCnt_d;

  // Scan farthest to nearest so the nearest matching producer is the last writer and wins.
  always_comb begin
    fwdSel  = '0;
    loadUse = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      for (int k = NSTG - 1; k >= 0; k--) begin
        if (hz.id_src_use[i] && hz.stg_wen[k] &&
            (hz.stg_reg[5*k +: 5] == hz.id_src_reg[5*i +: 5]) &&
            (hz.id_src_reg[5*i +: 5] != 5'd0)) begin
          fwdSel[i*FS_W +: FS_W] = FS_W'(k + 1);
        end
      end
      if ((fwdSel[i*FS_W +: FS_W] == FS_W'(1)) && hz.stg_is_load[0]) begin
        loadUse = 1'b1;
      end
    end
  end

  assign stallId = hz.id_valid & ~hz.flush & (loadUse | mduHaz);

`ifdef HAZ_MDU_INTERLOCK_EN
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  md_state_e          mdState_q;
  md_state_e          mdState_d;
  logic [CNT_W-1:0]   mdCnt_q;
  logic [CNT_W-1:0]   mdCnt_d;
  logic [CNT_W-1:0]   mdReload;
  logic               mdAccept;

  // The counter holds the remaining BUSY cycles minus one, so LAT-1 gives exactly LAT busy cycles.
  assign mdReload = hz.id_md_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
  assign mdAccept = hz.id_valid & hz.id_md_start & ~stallId & ~hz.flush;
  assign mduHaz   = hz.id_valid & (hz.id_md_start | hz.id_hilo_use) & (mdState_q == MD_BUSY);
  assign mdBusy   = (mdState_q == MD_BUSY);
  assign mdDone   = (mdState_q == MD_DONE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mdState_q <= MD_IDLE;
      mdCnt_q   <= '0;
    end else begin
      mdState_q <= mdState_d;
      mdCnt_q   <= mdCnt_d;
    end
  end

  always_comb begin
    mdState_d = mdState_q;
    mdCnt_d   = mdCnt_q;
    unique case (mdState_q)
      MD_IDLE: begin
        if (mdAccept) begin
          mdState_d = MD_BUSY;
          mdCnt_d   = mdReload;
        end
      end
      MD_BUSY: begin
        if (mdCnt_q == '0) begin
          mdState_d = MD_DONE;
        end else begin
          mdCnt_d = mdCnt_q - CNT_W'(1);
        end
      end
      MD_DONE: begin
        if (mdAccept) begin
          mdState_d = MD_BUSY;
          mdCnt_d   = mdReload;
        end else begin
          mdState_d = MD_IDLE;
        end
      end
      default: begin
        mdState_d = MD_IDLE;
        mdCnt_d   = '0;
      end
    endcase
  end
`else
  localparam int unusedLat = MUL_LAT + DIV_LAT;
  logic unusedMdu;

  assign unusedMdu = hz.id_md_start ^ hz.id_md_div ^ hz.id_hilo_use;
  assign mduHaz    = 1'b0;
  assign mdBusy    = 1'b0;
  assign mdDone    = 1'b0;
`endif

  assign stallCnt_d = (stallId && (stallCnt_q != 32'hFFFF_FFFF)) ? stallCnt_q + 32'd1 : stallCnt_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stallCnt_q <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
    end
  end

  assign hz.fwd_sel   = fwdSel;
  assign hz.stall_id  = stallId;
  assign hz.md_busy   = mdBusy;
  assign hz.md_done   = mdDone;
  assign hz.stall_cnt = stallCnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios pinned with literals, then random traffic
// checked every cycle against a behavioural model (MDU expectations follow HAZ_MDU_INTERLOCK_EN).
module tb_hazard_ctrl;
  localparam int NSRC    = 2;
  localparam int NSTG    = 2;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 32;
  localparam int FS_W    = $clog2(NSTG + 1);
`ifdef HAZ_MDU_INTERLOCK_EN
  localparam bit MDU_EN = 1'b1;
`else
  localparam bit MDU_EN = 1'b0;
`endif

  typedef struct {
    bit         valid;
    logic [4:0] src0;
    logic [4:0] src1;
    logic [1:0] srcUse;
    bit         mdStart;
    bit         mdDiv;
    bit         hilo;
    logic [1:0] wen;
    logic [4:0] dst0;
    logic [4:0] dst1;
    logic [1:0] load;
    bit         flush;
  } stim_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  int          mBusyLeft = 0;
  bit          mDone = 1'b0;
  logic [31:0] mStallCnt = '0;
  bit          armed = 1'b0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.NSRC(NSRC), .NSTG(NSTG)) hif ();

  hazard_ctrl #(
    .NSRC(NSRC), .NSTG(NSTG), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .hz(hif.slave)
  );

  function automatic stim_t idleStim();
    stim_t s;
    s.valid = 0; s.src0 = '0; s.src1 = '0; s.srcUse = '0; s.mdStart = 0; s.mdDiv = 0;
    s.hilo = 0; s.wen = '0; s.dst0 = '0; s.dst1 = '0; s.load = '0; s.flush = 0;
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s);
    hif.id_valid    = s.valid;
    hif.id_src_reg  = {s.src1, s.src0};
    hif.id_src_use  = s.srcUse;
    hif.id_md_start = s.mdStart;
    hif.id_md_div   = s.mdDiv;
    hif.id_hilo_use = s.hilo;
    hif.stg_wen     = s.wen;
    hif.stg_reg     = {s.dst1, s.dst0};
    hif.stg_is_load = s.load;
    hif.flush       = s.flush;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Nearest producer writing the same nonzero register, searched from EXE outward.
  function automatic int expSel(input int i);
    logic [4:0] r;
    r = hif.id_src_reg[5*i +: 5];
    if (!hif.id_src_use[i] || r == 5'd0) return 0;
    for (int k = 0; k < NSTG; k++) begin
      if (hif.stg_wen[k] && hif.stg_reg[5*k +: 5] == r) return k + 1;
    end
    return 0;
  endfunction

  function automatic bit expStall();
    bit dataHaz;
    bit mduHaz;
    dataHaz = 0;
    for (int i = 0; i < NSRC; i++) begin
      if (expSel(i) == 1 && hif.stg_is_load[0]) dataHaz = 1;
    end
    mduHaz = MDU_EN && hif.id_valid && (hif.id_md_start || hif.id_hilo_use) && (mBusyLeft > 0);
    return hif.id_valid && !hif.flush && (dataHaz || mduHaz);
  endfunction

  // Model state advances on each edge from the inputs that were held during the cycle.
  always @(posedge clk) begin
    bit st;
    bit acc;
    if (!resetn) begin
      mBusyLeft = 0;
      mDone     = 0;
      mStallCnt = '0;
      armed     = 1;
    end else begin
      st  = expStall();
      acc = MDU_EN && hif.id_valid && hif.id_md_start && !st && !hif.flush;
      if (st && mStallCnt != 32'hFFFF_FFFF) mStallCnt = mStallCnt + 1;
      if (mBusyLeft > 0) begin
        mBusyLeft = mBusyLeft - 1;
        mDone     = (mBusyLeft == 0);
      end else begin
        mDone = 0;
        if (acc) mBusyLeft = hif.id_md_div ? DIV_LAT : MUL_LAT;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < NSRC; i++) begin
        checkOutput($sformatf("model_fwd_sel%0d", i), 32'(hif.fwd_sel[i*FS_W +: FS_W]), 32'(expSel(i)));
      end
      checkOutput("model_stall_id", 32'(hif.stall_id), 32'(expStall()));
      checkOutput("model_md_busy", 32'(hif.md_busy), 32'(mBusyLeft > 0));
      checkOutput("model_md_done", 32'(hif.md_done), 32'(mDone));
      checkOutput("model_stall_cnt", hif.stall_cnt, mStallCnt);
    end
  end

  initial begin
    stim_t s;
    applyStimulus(idleStim());
    resetn = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_stall_cnt", hif.stall_cnt, 32'd0);
    checkOutput("reset_md_busy", 32'(hif.md_busy), 32'd0);
    checkOutput("reset_fwd_sel", 32'(hif.fwd_sel), 32'd0);
    checkOutput("reset_stall_id", 32'(hif.stall_id), 32'd0);
    nextCycle();
    resetn = 1'b1;

    // Two writers of $5: EXE wins.
    s = idleStim(); s.valid = 1; s.src0 = 5; s.srcUse = 2'b01; s.wen = 2'b11; s.dst0 = 5; s.dst1 = 5;
    applyStimulus(s);
    @(negedge clk);
    checkOutput("tp1_fwd_sel0", 32'(hif.fwd_sel[FS_W-1:0]), 32'd1);
    checkOutput("tp1_stall", 32'(hif.stall_id), 32'd0);
    nextCycle();

    s = idleStim(); s.valid = 1; s.src1 = 0; s.srcUse = 2'b10; s.wen = 2'b11; s.load = 2'b01;
    applyStimulus(s);
    @(negedge clk);
    checkOutput("tp2_r0_fwd_sel1", 32'(hif.fwd_sel[2*FS_W-1:FS_W]), 32'd0);
    checkOutput("tp2_r0_stall", 32'(hif.stall_id), 32'd0);
    nextCycle();

    s = idleStim(); s.valid = 1; s.src0 = 7; s.srcUse = 2'b01; s.wen = 2'b10; s.dst1 = 7; s.load = 2'b10;
    applyStimulus(s);
    @(negedge clk);
    checkOutput("tp2_far_load_sel0", 32'(hif.fwd_sel[FS_W-1:0]), 32'd2);
    checkOutput("tp2_far_load_stall", 32'(hif.stall_id), 32'd0);
    nextCycle();

    s = idleStim(); s.valid = 1; s.src0 = 8; s.srcUse = 2'b01; s.wen = 2'b01; s.dst0 = 8; s.load = 2'b01;
    applyStimulus(s);
    @(negedge clk);
    checkOutput("tp3_load_use_stall", 32'(hif.stall_id), 32'd1);
    nextCycle();
    s.wen = 2'b10; s.dst0 = 0; s.dst1 = 8; s.load = 2'b10;
    applyStimulus(s);
    @(negedge clk);
    checkOutput("tp3_after_sel0", 32'(hif.fwd_sel[FS_W-1:0]), 32'd2);
    checkOutput("tp3_after_stall", 32'(hif.stall_id), 32'd0);
    checkOutput("tp3_stall_cnt", hif.stall_cnt, 32'd1);
    nextCycle();

    // Flush over a load-use hazard with an MDU op in ID: no stall and no accept.
    s = idleStim(); s.valid = 1; s.src0 = 8; s.srcUse = 2'b01; s.wen = 2'b01; s.dst0 = 8; s.load = 2'b01;
    s.mdStart = 1; s.flush = 1;
    applyStimulus(s);
    @(negedge clk);
    checkOutput("flush_stall", 32'(hif.stall_id), 32'd0);
    nextCycle();
    applyStimulus(idleStim());
    @(negedge clk);
    checkOutput("flush_no_accept", 32'(hif.md_busy), 32'd0);
    checkOutput("flush_stall_cnt", hif.stall_cnt, 32'd1);
    nextCycle();

    // DIV accepted at edge T, MFLO waits behind it.
    s = idleStim(); s.valid = 1; s.mdStart = 1; s.mdDiv = 1;
    applyStimulus(s);
    nextCycle();
    s = idleStim(); s.valid = 1; s.hilo = 1;
    applyStimulus(s);
    for (int j = 1; j <= DIV_LAT; j++) begin
      @(negedge clk);
      checkOutput($sformatf("div_stall_T%0d", j), 32'(hif.stall_id), 32'(MDU_EN));
      checkOutput($sformatf("div_busy_T%0d", j), 32'(hif.md_busy), 32'(MDU_EN));
      nextCycle();
    end
    @(negedge clk);
    checkOutput("div_done", 32'(hif.md_done), 32'(MDU_EN));
    checkOutput("div_busy_end", 32'(hif.md_busy), 32'd0);
    checkOutput("div_mflo_go", 32'(hif.stall_id), 32'd0);
    nextCycle();

    // MULT, then a second MULT issued in DONE, then reset mid-BUSY.
    s = idleStim(); s.valid = 1; s.mdStart = 1;
    applyStimulus(s);
    nextCycle();
    applyStimulus(idleStim());
    nextCycle();
    nextCycle();
    applyStimulus(s);
    @(negedge clk);
    checkOutput("b2b_done", 32'(hif.md_done), 32'(MDU_EN));
    checkOutput("b2b_accept_stall", 32'(hif.stall_id), 32'd0);
    nextCycle();
    applyStimulus(idleStim());
    @(negedge clk);
    checkOutput("b2b_busy1", 32'(hif.md_busy), 32'(MDU_EN));
    checkOutput("b2b_not_done", 32'(hif.md_done), 32'd0);
    resetn = 1'b0;
    nextCycle();
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_busy", 32'(hif.md_busy), 32'd0);
    checkOutput("rst_stall_cnt", hif.stall_cnt, 32'd0);
    nextCycle();

    // Random traffic over a small register set to provoke frequent matches.
    for (int n = 0; n < 3000; n++) begin
      s.valid   = ($urandom_range(0, 7) != 0);
      s.src0    = 5'($urandom_range(0, 3));
      s.src1    = 5'($urandom_range(0, 3));
      s.srcUse  = 2'($urandom);
      s.mdStart = ($urandom_range(0, 9) == 0);
      s.mdDiv   = ($urandom_range(0, 3) == 0);
      s.hilo    = ($urandom_range(0, 4) == 0);
      s.wen     = 2'($urandom);
      s.dst0    = 5'($urandom_range(0, 3));
      s.dst1    = 5'($urandom_range(0, 3));
      s.load    = 2'($urandom);
      s.flush   = ($urandom_range(0, 15) == 0);
      applyStimulus(s);
      resetn = ($urandom_range(0, 299) != 0);
      nextCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
